// File: rtl/w_backward_merger_if.sv
// Merge bus for the B-token merger: per-slave token inputs plus the registered
// merged output. The merger uses the master modport and its environment uses the slave modport.
interface w_backward_merger_if #(
    parameter int NUM_SLAVES = 4
);
    localparam int SRC_W = $clog2(NUM_SLAVES);

    logic [NUM_SLAVES*14-1:0] S_DATA;
    logic [NUM_SLAVES-1:0]    S_VALID;
    logic [NUM_SLAVES-1:0]    S_READY;
    logic [13:0]              DATA;
    logic                     VALID;
    logic                     READY;
    logic [SRC_W-1:0]         SRC;

    modport master (
        input  S_DATA, S_VALID, READY,
        output S_READY, DATA, VALID, SRC
    );

    modport slave (
        output S_DATA, S_VALID, READY,
        input  S_READY, DATA, VALID, SRC
    );
endinterface

// File: rtl/w_backward_merger.sv
// Round-robin merger of NUM_SLAVES write-response tokens {BID, BRESP, BUSER}
// into one registered stream with a one-deep output slot and full throughput.
module w_backward_merger #(
    parameter int NUM_SLAVES = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    w_backward_merger_if.master   bus
);
    localparam int SRC_W = $clog2(NUM_SLAVES);
    localparam int TOK_W = 14;

    logic [TOK_W-1:0] slice [NUM_SLAVES];
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W:0]   cand;
    logic             grant_any;
    logic             load;
    logic             valid_q;
    logic [TOK_W-1:0] data_q;
    logic [SRC_W-1:0] src_q;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slice
        assign slice[i] = bus.S_DATA[TOK_W*i +: TOK_W];
    end

    // Output slot is free when empty or draining this cycle.
    assign load = ~valid_q | bus.READY;

    // Circular search from ptr; the explicit wrap keeps non-power-of-two counts correct.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            cand = {1'b0, ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_SLAVES)) begin
                cand = cand - (SRC_W+1)'(NUM_SLAVES);
            end
            if (!grant_any && bus.S_VALID[cand[SRC_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        bus.S_READY = '0;
        if (ARESETn && load && grant_any) begin
            bus.S_READY[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (grant_any) begin
                valid_q <= 1'b1;
                data_q  <= slice[grant_idx];
                src_q   <= grant_idx;
                ptr     <= (grant_idx == SRC_W'(NUM_SLAVES-1)) ? '0 : grant_idx + 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.VALID = valid_q;
    assign bus.DATA  = data_q;
    assign bus.SRC   = src_q;
endmodule

// File: tb/tb_w_backward_merger.sv
// Bench for w_backward_merger: directed reset/round-robin/backpressure/wrap steps,
// randomized traffic against a queue-free arbitration model, and a 3-slave instance.
module tb_w_backward_merger;
    logic ACLK = 1'b0;
    logic ARESETn;

    always #5 ACLK = ~ACLK;

    w_backward_merger_if #(.NUM_SLAVES(4)) bus4();
    w_backward_merger_if #(.NUM_SLAVES(3)) bus3();

    w_backward_merger #(.NUM_SLAVES(4)) dut4 (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus4));
    w_backward_merger #(.NUM_SLAVES(3)) dut3 (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus3));

    int n_total = 0;
    int n_pass  = 0;

    // reference model state for the 4-slave instance
    int          m_valid, m_ptr, m_src;
    logic [13:0] m_data;
    logic [3:0]  sv;
    logic [13:0] sd [4];
    logic [3:0]  last_acc;
    logic [13:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] rr_val(input int i);
        logic [7:0] bid;
        logic [1:0] resp;
        bid  = 8'h10 + 8'(i);
        resp = 2'(i);
        return {bid, resp, 4'hA};
    endfunction

    task automatic m_reset();
        m_valid = 0;
        m_ptr   = 0;
        m_src   = 0;
        m_data  = '0;
    endtask

    // Called at a negedge: drive, check accept, step model at posedge, check outputs.
    task automatic cyc(input logic rdy);
        int       g;
        logic     ld;
        logic [3:0] exp_rdy;
        bus4.READY   = rdy;
        bus4.S_VALID = sv;
        for (int i = 0; i < 4; i++) bus4.S_DATA[14*i +: 14] = sd[i];
        #1;
        ld = (m_valid == 0) || rdy;
        g  = -1;
        if (ld) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && sv[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("s_ready", 32'(bus4.S_READY), 32'(exp_rdy));
        last_acc = exp_rdy;
        @(posedge ACLK);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = sd[g];
                m_src   = g;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge ACLK);
        chk("valid", 32'(bus4.VALID), 32'(m_valid));
        chk("data",  32'(bus4.DATA),  32'(m_data));
        chk("src",   32'(bus4.SRC),   32'(m_src));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn       = 1'b1;
        bus4.READY    = 1'b1;
        bus4.S_VALID  = '0;
        bus4.S_DATA   = '0;
        bus3.READY    = 1'b1;
        bus3.S_VALID  = '0;
        bus3.S_DATA   = {14'h102, 14'h101, 14'h100};
        last_acc      = '0;
        held          = '0;
        m_reset();

        // reset with all slaves requesting
        #2 ARESETn = 1'b0;
        sv = 4'b1111;
        for (int i = 0; i < 4; i++) sd[i] = rr_val(i);
        bus4.S_VALID = sv;
        for (int i = 0; i < 4; i++) bus4.S_DATA[14*i +: 14] = sd[i];
        @(negedge ACLK);
        chk("rst_s_ready", 32'(bus4.S_READY), 32'h0);
        chk("rst_valid",   32'(bus4.VALID),   32'h0);
        chk("rst_data",    32'(bus4.DATA),    32'h0);
        chk("rst_src",     32'(bus4.SRC),     32'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // round robin, no bubbles
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1);
            chk("rr_src",  32'(bus4.SRC),  32'(k % 4));
            chk("rr_data", 32'(bus4.DATA), 32'(rr_val(k % 4)));
        end

        // backpressure after a grant to slave 1
        sv = 4'b0010;
        cyc(1'b1);
        held = sd[1];
        chk("bp_first_src", 32'(bus4.SRC), 32'd1);
        sv = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0);
            chk("bp_frozen_data", 32'(bus4.DATA), 32'(held));
            chk("bp_frozen_src",  32'(bus4.SRC),  32'd1);
        end
        cyc(1'b1);
        chk("bp_next_src", 32'(bus4.SRC), 32'd2);

        // sparse traffic and pointer wrap
        sv = 4'b1000;
        cyc(1'b1);
        chk("wrap_src3", 32'(bus4.SRC), 32'd3);
        sv = 4'b1001;
        cyc(1'b1);
        chk("wrap_src0", 32'(bus4.SRC), 32'd0);

        // randomized traffic; a slave keeps its token until accepted
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'($urandom_range(0, 1));
            sd[i] = 14'($urandom);
        end
        for (int n = 0; n < 300; n++) begin
            cyc($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) begin
                if (!sv[i] || last_acc[i]) begin
                    sv[i] = 1'($urandom_range(0, 1));
                    sd[i] = 14'($urandom);
                end
            end
        end

        // reset while a token is held under backpressure
        sv    = 4'b0001;
        sd[0] = 14'h1234;
        cyc(1'b1);
        cyc(1'b0);
        chk("mrst_pre_valid", 32'(bus4.VALID), 32'd1);
        #2 ARESETn = 1'b0;
        #1;
        chk("mrst_valid",   32'(bus4.VALID),   32'h0);
        chk("mrst_data",    32'(bus4.DATA),    32'h0);
        chk("mrst_src",     32'(bus4.SRC),     32'h0);
        chk("mrst_s_ready", 32'(bus4.S_READY), 32'h0);
        m_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
        sv = 4'b1111;
        cyc(1'b1);
        chk("mrst_first_src", 32'(bus4.SRC), 32'd0);

        // three-slave instance: 0,1,2,0,... never 3
        bus3.S_VALID = 3'b111;
        for (int k = 0; k < 7; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            chk("n3_valid", 32'(bus3.VALID), 32'd1);
            chk("n3_src",   32'(bus3.SRC),   32'(k % 3));
            chk("n3_data",  32'(bus3.DATA),  32'(14'h100 + 14'(k % 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
